multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller:
// state codes, opcodes and ALU select encodings.
package ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_EXEC_R   = 4'd3;
  localparam state_t S_EXEC_I   = 4'd4;
  localparam state_t S_MEM_ADDR = 4'd5;
  localparam state_t S_MEM_RD   = 4'd6;
  localparam state_t S_MEM_WB   = 4'd7;
  localparam state_t S_MEM_WR   = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_ALU_WB   = 4'd10;
  localparam state_t S_HALT     = 4'd11;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-wait cycles and flags the
// cycle on which the controller must give up.
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  input  logic mem_ready,
  input  logic state_chg,
  output logic timeout
);

  localparam int CLG = $clog2(TIMEOUT_CYC + 1);
  localparam int CW  = (CLG > 4) ? CLG : 4;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_chg || mem_ready || !wait_en)
      cnt_d = '0;
  end

  // a ready cycle never times out
  assign timeout = wait_en && !mem_ready
                   && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch,
// decode, execute, memory and writeback steps.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       halted
);

  state_t state_q;
  state_t state_d;
  logic   timeout;
  logic   wait_en;
  logic   is_r, is_i, is_ld, is_st, is_br;

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LOAD);
  assign is_st = (opcode == OP_STORE);
  assign is_br = (opcode == OP_BR);

  assign wait_en = (state_q == S_FETCH)
                 | (state_q == S_MEM_RD)
                 | (state_q == S_MEM_WR);

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wait_en   (wait_en),
    .mem_ready (mem_ready),
    .state_chg (state_d != state_q),
    .timeout   (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r:          state_d = S_EXEC_R;
          is_i:          state_d = S_EXEC_I;
          is_ld, is_st:  state_d = S_MEM_ADDR;
          is_br:         state_d = S_BRANCH;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_HALT;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_HALT;
      end
      S_BRANCH:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  always_comb begin
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_BOFF;
        illegal_op = !(is_r | is_i | is_ld | is_st | is_br);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB:   reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD:   mem_read = 1'b1;
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR:   mem_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      S_HALT:     halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl: per-cycle
// expected output vectors queued and compared.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write, pc_write_cond, pc_source;
  logic       ir_write, mem_read, mem_write;
  logic       reg_write, mem_to_reg;
  logic       illegal_op, halted;

  multicycle_ctrl #(.TIMEOUT_CYC(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .illegal_op    (illegal_op),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {alu_op, src_a, src_b, pcw, pcc, pcs,
  //  ir, mrd, mwr, rw, m2r, ill, halt}
  logic [14:0] outv;
  assign outv = {alu_op, alu_src_a, alu_src_b,
                 pc_write, pc_write_cond, pc_source,
                 ir_write, mem_read, mem_write,
                 reg_write, mem_to_reg, illegal_op,
                 halted};

  localparam logic [14:0] E_IDLE    = 15'b00_0_00_000_0000000;
  localparam logic [14:0] E_FETCH   = 15'b00_0_01_000_0100000;
  localparam logic [14:0] E_FETCH_R = 15'b00_0_01_100_1100000;
  localparam logic [14:0] E_DEC     = 15'b00_0_11_000_0000000;
  localparam logic [14:0] E_DEC_ILL = 15'b00_0_11_000_0000010;
  localparam logic [14:0] E_EXR     = 15'b10_1_00_000_0000000;
  localparam logic [14:0] E_EXI     = 15'b10_1_10_000_0000000;
  localparam logic [14:0] E_ALUWB   = 15'b00_0_00_000_0001000;
  localparam logic [14:0] E_MADDR   = 15'b00_1_10_000_0000000;
  localparam logic [14:0] E_MRD     = 15'b00_0_00_000_0100000;
  localparam logic [14:0] E_MWB     = 15'b00_0_00_000_0001100;
  localparam logic [14:0] E_MWR     = 15'b00_0_00_000_0010000;
  localparam logic [14:0] E_BR      = 15'b01_1_00_011_0000000;
  localparam logic [14:0] E_HALT    = 15'b00_0_00_000_0000001;

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_BAD = 7'b1111111;

  typedef struct packed {
    logic [6:0]  opc;
    logic        rdy;
    logic [14:0] exp;
  } step_t;

  int total = 0;
  int bad   = 0;
  logic [14:0] sb[$];
  logic [14:0] want;

  function automatic step_t mk(logic [6:0] o,
                               logic r,
                               logic [14:0] e);
    step_t s;
    s.opc = o;
    s.rdy = r;
    s.exp = e;
    return s;
  endfunction

  // pulse reset; returns on the release negedge
  task automatic pulse_reset();
    rst_n     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    opcode    = O_R;
    mem_ready = 1'b1;
    #3;
    total++;
    if (outv !== E_IDLE) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h",
               outv, E_IDLE);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (outv !== E_IDLE) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h",
               outv, E_IDLE);
    end
  endtask

  task automatic test_rtype();
    step_t st[$];
    st.push_back(mk(O_R, 1'b1, E_IDLE));
    st.push_back(mk(O_R, 1'b1, E_FETCH_R));
    st.push_back(mk(O_R, 1'b1, E_DEC));
    st.push_back(mk(O_R, 1'b1, E_EXR));
    st.push_back(mk(O_R, 1'b1, E_ALUWB));
    st.push_back(mk(O_R, 1'b0, E_FETCH));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL rtype[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_itype();
    step_t st[$];
    st.push_back(mk(O_I, 1'b0, E_IDLE));
    st.push_back(mk(O_I, 1'b1, E_FETCH_R));
    st.push_back(mk(O_I, 1'b1, E_DEC));
    st.push_back(mk(O_I, 1'b0, E_EXI));
    st.push_back(mk(O_I, 1'b1, E_ALUWB));
    st.push_back(mk(O_I, 1'b0, E_FETCH));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL itype[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    step_t st[$];
    st.push_back(mk(O_LD, 1'b0, E_IDLE));
    st.push_back(mk(O_LD, 1'b1, E_FETCH_R));
    st.push_back(mk(O_LD, 1'b1, E_DEC));
    st.push_back(mk(O_LD, 1'b1, E_MADDR));
    for (int k = 0; k < 3; k++)
      st.push_back(mk(O_LD, 1'b0, E_MRD));
    st.push_back(mk(O_LD, 1'b1, E_MRD));
    st.push_back(mk(O_LD, 1'b1, E_MWB));
    st.push_back(mk(O_LD, 1'b0, E_FETCH));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL load[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_wait();
    step_t st[$];
    st.push_back(mk(O_ST, 1'b0, E_IDLE));
    st.push_back(mk(O_ST, 1'b1, E_FETCH_R));
    st.push_back(mk(O_ST, 1'b0, E_DEC));
    st.push_back(mk(O_ST, 1'b0, E_MADDR));
    st.push_back(mk(O_ST, 1'b0, E_MWR));
    st.push_back(mk(O_ST, 1'b0, E_MWR));
    st.push_back(mk(O_ST, 1'b1, E_MWR));
    st.push_back(mk(O_ST, 1'b0, E_FETCH));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL store[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    step_t st[$];
    st.push_back(mk(O_R, 1'b0, E_IDLE));
    for (int k = 0; k < 15; k++)
      st.push_back(mk(O_R, 1'b0, E_FETCH));
    st.push_back(mk(O_R, 1'b0, E_HALT));
    st.push_back(mk(O_R, 1'b1, E_HALT));
    st.push_back(mk(O_R, 1'b1, E_HALT));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL timeout[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout_race();
    step_t st[$];
    st.push_back(mk(O_R, 1'b0, E_IDLE));
    for (int k = 0; k < 14; k++)
      st.push_back(mk(O_R, 1'b0, E_FETCH));
    st.push_back(mk(O_R, 1'b1, E_FETCH_R));
    st.push_back(mk(O_R, 1'b0, E_DEC));
    st.push_back(mk(O_R, 1'b0, E_EXR));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL race[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_branch();
    step_t st[$];
    st.push_back(mk(O_BAD, 1'b0, E_IDLE));
    st.push_back(mk(O_BAD, 1'b1, E_FETCH_R));
    st.push_back(mk(O_BAD, 1'b1, E_DEC_ILL));
    st.push_back(mk(O_BAD, 1'b0, E_FETCH));
    st.push_back(mk(O_BR, 1'b1, E_FETCH_R));
    st.push_back(mk(O_BR, 1'b0, E_DEC));
    st.push_back(mk(O_BR, 1'b1, E_BR));
    st.push_back(mk(O_BR, 1'b0, E_FETCH));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL illbr[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_store();
    step_t st[$];
    step_t st2[$];
    st.push_back(mk(O_ST, 1'b0, E_IDLE));
    st.push_back(mk(O_ST, 1'b1, E_FETCH_R));
    st.push_back(mk(O_ST, 1'b0, E_DEC));
    st.push_back(mk(O_ST, 1'b0, E_MADDR));
    st2.push_back(mk(O_ST, 1'b1, E_IDLE));
    st2.push_back(mk(O_ST, 1'b0, E_FETCH));
    st2.push_back(mk(O_ST, 1'b0, E_FETCH));
    pulse_reset();
    for (int i = 0; i < st.size(); i++) begin
      opcode = st[i].opc;
      mem_ready = st[i].rdy;
      sb.push_back(st[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL midst[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #2;
    total++;
    if (outv !== E_MWR) begin
      bad++;
      $display("FAIL midst_wr got=%h want=%h",
               outv, E_MWR);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0 || outv !== E_IDLE) begin
      bad++;
      $display("FAIL midst_abort got=%h want=%h",
               outv, E_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < st2.size(); i++) begin
      opcode = st2[i].opc;
      mem_ready = st2[i].rdy;
      sb.push_back(st2[i].exp);
      #2;
      want = sb.pop_front();
      total++;
      if (outv !== want) begin
        bad++;
        $display("FAIL midst_rel[%0d] got=%h want=%h",
                 i, outv, want);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store_wait();
    test_timeout();
    test_timeout_race();
    test_illegal_branch();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
